// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target register window: the protocol FSM
// state encoding and the bus-level polarity constants.
// No ports.
// -----------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_ACK
   } i2c_state_e;

   // Value of the R/W bit that requests a read transfer.
   localparam logic I2C_RW_READ = 1'b1;
   // SDA level of an acknowledge bit.
   localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_cond.sv
// -----------------------------------------------------------------------------
// i2c_line_cond
// Conditions the asynchronous SCL/SDA pair for the target FSM: two-flop
// synchronisers (reset to the idle-bus level 1), an optional 3-sample majority
// filter, and edge / START / STOP detection against a 1-clk-delayed copy.
//
// Optional feature: define I2C_TARGET_GLITCH_FILTER_EN to insert the majority
// filter (rejects pulses shorter than 2 clk, adds 2 clk of latency).
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   scl_i      in   raw SCL line
//   sda_i      in   raw SDA line
//   sda_o      out  conditioned SDA level (for sampling data bits)
//   scl_rise_o out  1-clk pulse on conditioned SCL rising edge
//   scl_fall_o out  1-clk pulse on conditioned SCL falling edge
//   start_o    out  1-clk pulse: SDA fell while SCL high
//   stop_o     out  1-clk pulse: SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_line_cond
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_cur;
   logic       sda_cur;
   logic       scl_prev_q;
   logic       sda_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [2:0] scl_hist_q;
   logic [2:0] sda_hist_q;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_hist_q <= 3'b111;
         sda_hist_q <= 3'b111;
      end else begin
         scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
      end
   end

   // A level must occupy two of the three history taps before it passes,
   // so a single-clk pulse never reaches the edge detectors.
   assign scl_cur = maj3(scl_hist_q);
   assign sda_cur = maj3(sda_hist_q);
`else
   assign scl_cur = scl_sync_q[1];
   assign sda_cur = sda_sync_q[1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_cur;
         sda_prev_q <= sda_cur;
      end
   end

   assign sda_o      = sda_cur;
   assign scl_rise_o =  scl_cur & ~scl_prev_q;
   assign scl_fall_o = ~scl_cur &  scl_prev_q;
   // SCL must be high on both samples so an SDA change that coincides with an
   // SCL edge is never mistaken for a bus condition.
   assign start_o    = scl_cur & scl_prev_q &  sda_prev_q & ~sda_cur;
   assign stop_o     = scl_cur & scl_prev_q & ~sda_prev_q &  sda_cur;

endmodule

// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
// I2C target exposing a window of 2**REG_AW 8-bit registers to local logic.
// The first byte written after the address is the register pointer; further
// written bytes store with auto-increment; reads stream registers starting at
// the pointer. The pointer survives a repeated START (pointer-write-then-read).
//
// Optional feature: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_cond).
//
// Ports:
//   clk        in   system clock, >= 8x SCL
//   rst        in   synchronous active-high reset
//   scl_in     in   SCL line level (asynchronous)
//   sda_in     in   SDA line level (asynchronous)
//   sda_oe     out  1 = pull SDA low
//   reg_addr   out  current register pointer
//   reg_wr_en  out  one-clk write strobe
//   reg_wdata  out  write data, valid with reg_wr_en
//   reg_rd_en  out  one-clk pulse when reg_rdata is captured
//   reg_rdata  in   combinational read data for reg_addr
//   busy       out  high from a matched address until STOP or START
// -----------------------------------------------------------------------------
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         REG_AW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [REG_AW-1:0] reg_addr,
   output logic              reg_wr_en,
   output logic [7:0]        reg_wdata,
   output logic              reg_rd_en,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   logic sda_lvl;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_line_cond u_line (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_lvl),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              ph_q, ph_d;       // ACK slot: 0 = slot not yet opened
   logic              mack_q, mack_d;   // master acknowledged the read byte
   logic              oe_q, oe_d;
   logic [REG_AW-1:0] addr_q, addr_d;
   logic              wr_en_q, wr_en_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic [6:0]        shift_q, shift_d; // received bits; MSB falls off at byte end
   logic [6:0]        tx_q, tx_d;       // remaining read bits after the one on SDA
   logic [7:0]        byte_in;

   assign byte_in = {shift_q, sda_lvl};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      mack_d  = mack_q;
      oe_d    = oe_q;
      addr_d  = addr_q;
      wr_en_d = 1'b0;
      wdata_d = wdata_q;
      rd_en_d = 1'b0;
      busy_d  = busy_q;
      shift_d = shift_q;
      tx_d    = tx_q;

      if (stop_det) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         ph_d    = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (start_det) begin
         state_d = ADDR;
         cnt_d   = 3'd0;
         ph_d    = 1'b0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;

            ADDR: begin
               if (scl_rise) begin
                  shift_d = byte_in[6:0];
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (byte_in[7:1] == SLAVE_ADDR) begin
                        state_d = ADDR_ACK;
                        busy_d  = 1'b1;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ph_q) begin
                     oe_d = 1'b1;
                     ph_d = 1'b1;
                  end else begin
                     ph_d = 1'b0;
                     // shift_q[0] still holds the R/W bit of the address byte.
                     if (shift_q[0] == I2C_RW_READ) begin
                        state_d = READ;
                        tx_d    = reg_rdata[6:0];
                        rd_en_d = 1'b1;
                        oe_d    = ~reg_rdata[7];
                     end else begin
                        state_d = PTR;
                        oe_d    = 1'b0;
                     end
                  end
               end
            end

            PTR: begin
               if (scl_rise) begin
                  shift_d = byte_in[6:0];
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     addr_d  = byte_in[REG_AW-1:0];
                     state_d = PTR_ACK;
                  end
               end
            end

            PTR_ACK: begin
               if (scl_fall) begin
                  if (!ph_q) begin
                     oe_d = 1'b1;
                     ph_d = 1'b1;
                  end else begin
                     oe_d    = 1'b0;
                     ph_d    = 1'b0;
                     state_d = WRITE;
                  end
               end
            end

            WRITE: begin
               if (scl_rise) begin
                  shift_d = byte_in[6:0];
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     wr_en_d = 1'b1;
                     wdata_d = byte_in;
                     state_d = WRITE_ACK;
                  end
               end
            end

            WRITE_ACK: begin
               if (scl_fall) begin
                  if (!ph_q) begin
                     oe_d = 1'b1;
                     ph_d = 1'b1;
                  end else begin
                     oe_d    = 1'b0;
                     ph_d    = 1'b0;
                     addr_d  = addr_q + REG_AW'(1);
                     state_d = WRITE;
                  end
               end
            end

            READ: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = READ_ACK;
                  end
               end else if (scl_fall) begin
                  oe_d = ~tx_q[6];
                  tx_d = {tx_q[5:0], 1'b0};
               end
            end

            READ_ACK: begin
               if (scl_fall) begin
                  if (!ph_q) begin
                     oe_d = 1'b0;
                     ph_d = 1'b1;
                  end else begin
                     ph_d = 1'b0;
                     if (mack_q) begin
                        state_d = READ;
                        tx_d    = reg_rdata[6:0];
                        rd_en_d = 1'b1;
                        oe_d    = ~reg_rdata[7];
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end else if (scl_rise && ph_q) begin
                  // Advance the pointer as soon as the ACK is seen so that
                  // reg_rdata already reflects the next register at the fall.
                  mack_d = (sda_lvl == I2C_ACK);
                  if (sda_lvl == I2C_ACK) begin
                     addr_d = addr_q + REG_AW'(1);
                  end
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         ph_q    <= 1'b0;
         mack_q  <= 1'b0;
         oe_q    <= 1'b0;
         addr_q  <= '0;
         wr_en_q <= 1'b0;
         wdata_q <= 8'h00;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         mack_q  <= mack_d;
         oe_q    <= oe_d;
         addr_q  <= addr_d;
         wr_en_q <= wr_en_d;
         wdata_q <= wdata_d;
         rd_en_q <= rd_en_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      tx_q    <= tx_d;
   end

   assign sda_oe    = oe_q;
   assign reg_addr  = addr_q;
   assign reg_wr_en = wr_en_q;
   assign reg_wdata = wdata_q;
   assign reg_rd_en = rd_en_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regs
// Directed bench for i2c_target_regs. A bit-level master drives SCL at clk/16
// onto a wired-AND SDA line; a register model answers reg[n] = 0x30 + n.
// -----------------------------------------------------------------------------
module tb_i2c_target_regs;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m;
   logic       sda_m;
   logic       sda_line;
   logic       sda_oe;
   logic [2:0] reg_addr;
   logic       reg_wr_en;
   logic [7:0] reg_wdata;
   logic       reg_rd_en;
   logic [7:0] reg_rdata;
   logic       busy;

   int checks = 0;
   int errors = 0;

   assign sda_line  = sda_m & ~sda_oe;
   assign reg_rdata = 8'h30 + {5'd0, reg_addr};

   always #5 clk = ~clk;

   i2c_target_regs #(.SLAVE_ADDR(7'h50), .REG_AW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wr_en (reg_wr_en),
      .reg_wdata (reg_wdata),
      .reg_rd_en (reg_rd_en),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   // Passive monitor of strobes and activity.
   int         wr_n = 0;
   int         rd_n = 0;
   int         oe_cnt = 0;
   int         busy_cnt = 0;
   logic [2:0] wr_addr_log [0:63];
   logic [7:0] wr_data_log [0:63];

   always @(negedge clk) begin
      if (reg_wr_en) begin
         wr_addr_log[wr_n[5:0]] <= reg_addr;
         wr_data_log[wr_n[5:0]] <= reg_wdata;
         wr_n <= wr_n + 1;
      end
      if (reg_rd_en) rd_n <= rd_n + 1;
      if (sda_oe)    oe_cnt <= oe_cnt + 1;
      if (busy)      busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1);
   end

   // ---------------- master primitives ----------------
   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      clks(4); sda_m = b;
      clks(4); scl_m = 1'b1;
      clks(4); s = sda_line;
      clks(4); scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      clks(4); sda_m = 1'b1;
      clks(4); scl_m = 1'b1;
      clks(4); sda_m = 1'b0;
      clks(4); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      clks(4); sda_m = 1'b0;
      clks(4); scl_m = 1'b1;
      clks(4); sda_m = 1'b1;
      clks(8);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
      i2c_bit(1'b1, s);
      ack = (s == 1'b0);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         i2c_bit(1'b1, s);
         d = {d[6:0], s};
      end
      i2c_bit(mack ? 1'b0 : 1'b1, s);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      clks(3);
      checks++; if (sda_oe !== 1'b0)      begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      checks++; if (reg_wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
      checks++; if (reg_rd_en !== 1'b0)   begin errors++; $display("FAIL reset_rd_en: got %b want 0", reg_rd_en); end
      checks++; if (reg_wdata !== 8'h00)  begin errors++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
      checks++; if (reg_addr !== 3'd0)    begin errors++; $display("FAIL reset_addr: got %0d want 0", reg_addr); end
      checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      clks(4);
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int   w0;
      w0 = wr_n;
      i2c_start();
      send_byte(8'hA0, a0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_matched: got %b want 1", busy); end
      send_byte(8'h02, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      i2c_stop();
      checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL write_acks: got %b want 1111", {a0, a1, a2, a3}); end
      checks++; if (wr_n - w0 !== 2) begin errors++; $display("FAIL write_strobe_count: got %0d want 2", wr_n - w0); end
      checks++; if (wr_addr_log[w0] !== 3'd2)   begin errors++; $display("FAIL write0_addr: got %0d want 2", wr_addr_log[w0]); end
      checks++; if (wr_data_log[w0] !== 8'h11)  begin errors++; $display("FAIL write0_data: got %h want 11", wr_data_log[w0]); end
      checks++; if (wr_addr_log[w0+1] !== 3'd3) begin errors++; $display("FAIL write1_addr: got %0d want 3", wr_addr_log[w0+1]); end
      checks++; if (wr_data_log[w0+1] !== 8'h22) begin errors++; $display("FAIL write1_data: got %h want 22", wr_data_log[w0+1]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
      checks++; if (reg_addr !== 3'd4) begin errors++; $display("FAIL write_final_addr: got %0d want 4", reg_addr); end
   endtask

   // Pointer 5, repeated START, read n bytes (last one NACKed).
   task automatic test_read(input int n, input logic [2:0] final_addr);
      logic       a0, a1, a2;
      logic [7:0] d;
      logic [7:0] exp_d [0:3];
      int         r0;
      exp_d[0] = 8'h35; exp_d[1] = 8'h36; exp_d[2] = 8'h37; exp_d[3] = 8'h30;
      r0 = rd_n;
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h05, a1);
      i2c_start();
      send_byte(8'hA1, a2);
      checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL read%0d_acks: got %b want 111", n, {a0, a1, a2}); end
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, d);
         checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL read%0d_byte%0d: got %h want %h", n, i, d, exp_d[i]); end
      end
      i2c_stop();
      checks++; if (rd_n - r0 !== n) begin errors++; $display("FAIL read%0d_rd_en_count: got %0d want %0d", n, rd_n - r0, n); end
      checks++; if (reg_addr !== final_addr) begin errors++; $display("FAIL read%0d_final_addr: got %0d want %0d", n, reg_addr, final_addr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read%0d_busy: got %b want 0", n, busy); end
   endtask

   task automatic test_mismatch();
      logic a0, a1, a2;
      int   w0, r0, o0, b0;
      w0 = wr_n; r0 = rd_n; o0 = oe_cnt; b0 = busy_cnt;
      i2c_start();
      send_byte(8'h90, a0);
      send_byte(8'h12, a1);
      send_byte(8'h34, a2);
      i2c_stop();
      checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL mismatch_acks: got %b want 000", {a0, a1, a2}); end
      checks++; if (oe_cnt - o0 !== 0)   begin errors++; $display("FAIL mismatch_sda_oe: got %0d cycles want 0", oe_cnt - o0); end
      checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL mismatch_busy: got %0d cycles want 0", busy_cnt - b0); end
      checks++; if (wr_n - w0 !== 0)     begin errors++; $display("FAIL mismatch_wr_en: got %0d want 0", wr_n - w0); end
      checks++; if (rd_n - r0 !== 0)     begin errors++; $display("FAIL mismatch_rd_en: got %0d want 0", rd_n - r0); end
   endtask

   task automatic test_abort();
      logic a0, a1, s;
      int   w0;
      w0 = wr_n;
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h01, a1);
      i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s); i2c_bit(1'b0, s);
      i2c_stop();
      checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL abort_acks: got %b want 11", {a0, a1}); end
      checks++; if (wr_n - w0 !== 0)  begin errors++; $display("FAIL abort_wr_en: got %0d want 0", wr_n - w0); end
      checks++; if (sda_oe !== 1'b0)  begin errors++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if (reg_addr !== 3'd1) begin errors++; $display("FAIL abort_addr: got %0d want 1", reg_addr); end
   endtask

   task automatic test_reset_mid_ack();
      logic       s, a0, a1, a2;
      logic [7:0] addr_byte;
      int         w0;
      addr_byte = 8'hA0;
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(addr_byte[i], s);
      clks(4); sda_m = 1'b1;
      clks(4);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstack_oe_before: got %b want 1", sda_oe); end
      rst = 1'b1;
      clks(1);
      checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL rstack_sda_oe: got %b want 0", sda_oe); end
      checks++; if (reg_addr !== 3'd0) begin errors++; $display("FAIL rstack_addr: got %0d want 0", reg_addr); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstack_busy: got %b want 0", busy); end
      rst = 1'b0;
      clks(2); scl_m = 1'b1;
      clks(8);
      w0 = wr_n;
      i2c_start();
      send_byte(8'hA0, a0);
      send_byte(8'h06, a1);
      send_byte(8'h5A, a2);
      i2c_stop();
      checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL rstack_post_acks: got %b want 111", {a0, a1, a2}); end
      checks++; if (wr_n - w0 !== 1) begin errors++; $display("FAIL rstack_post_wr_count: got %0d want 1", wr_n - w0); end
      checks++; if (wr_addr_log[w0] !== 3'd6)  begin errors++; $display("FAIL rstack_post_addr: got %0d want 6", wr_addr_log[w0]); end
      checks++; if (wr_data_log[w0] !== 8'h5A) begin errors++; $display("FAIL rstack_post_data: got %h want 5a", wr_data_log[w0]); end
   endtask

   task automatic test_glitch();
      logic a0;
      logic exp_busy;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      i2c_start();
      send_byte(8'hA0, a0);
      checks++; if (a0 !== 1'b1)   begin errors++; $display("FAIL glitch_ack: got %b want 1", a0); end
      clks(4); sda_m = 1'b1;
      clks(4); scl_m = 1'b1;
      clks(3);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_before: got %b want 1", busy); end
      sda_m = 1'b0;
      clks(1);
      sda_m = 1'b1;
      clks(8);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL glitch_busy_after: got %b want %b", busy, exp_busy); end
      scl_m = 1'b0;
      i2c_stop();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_stop: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read(3, 3'd7);
      test_read(4, 3'd0);
      test_mismatch();
      test_abort();
      test_reset_mid_ack();
      test_glitch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
